// File: rtl/ula_pkg.sv
// Shared types and constants for the nibble-serial 16-bit 74181 ALU.
package ula_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIBBLES = 4;
    localparam int IDX_W   = $clog2(NIBBLES);

    // Function select codes (active-high data convention)
    localparam logic [3:0] S_ADD  = 4'b1001;
    localparam logic [3:0] S_SUB  = 4'b0110;
    localparam logic [3:0] S_XOR  = 4'b0110;  // with m = 1
    localparam logic [3:0] S_AINC = 4'b0000;  // with c_in = 0

endpackage

// File: rtl/ula_74181.sv
// 4-bit combinational 74181 slice, active-high data, active-low carry in/out.
module ula_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out
);

    logic [3:0] t1;
    logic [3:0] t2;
    logic [4:0] sum;

    // Arithmetic is t2 plus t1 plus carry; logic mode is the carry-free XNOR of the same terms
    assign t1    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign t2    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    assign sum   = {1'b0, t1} + {1'b0, t2} + {4'b0000, ~c_in};
    assign f     = m ? ~(t1 ^ t2) : sum[3:0];
    assign c_out = ~sum[4];

endmodule

// File: rtl/ula_seq16.sv
// 16-bit ALU built by running one 74181 slice over four nibbles, LSB first.
//   state   | meaning
//   IDLE    | waiting for start, outputs hold last result
//   RUN     | one nibble per cycle through the slice, idx 0..3
//   DONE    | result registered, done pulse high for one cycle
module ula_seq16
    import ula_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  s,
    input  logic        m,
    input  logic        c_in,
    output logic [15:0] f,
    output logic        c_out,
    output logic        a_eq_b,
    output logic        busy,
    output logic        done
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      a_r;
    logic [15:0]      b_r;
    logic [3:0]       s_r;
    logic             m_r;
    logic             carry;
    logic [11:0]      res;

    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_f;
    logic             sl_c;
    logic [15:0]      full;

    assign sl_a = a_r[{idx, 2'b00} +: 4];
    assign sl_b = b_r[{idx, 2'b00} +: 4];
    assign full = {sl_f, res};

    ula_74181 u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .s     (s_r),
        .m     (m_r),
        .c_in  (carry),
        .f     (sl_f),
        .c_out (sl_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            m_r    <= 1'b0;
            carry  <= 1'b1;
            res    <= '0;
            f      <= 16'h0000;
            c_out  <= 1'b1;
            a_eq_b <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        s_r   <= s;
                        m_r   <= m;
                        carry <= c_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= sl_c;
                    idx   <= idx + 1'b1;
                    case (idx)
                        2'd0:    res[3:0]  <= sl_f;
                        2'd1:    res[7:4]  <= sl_f;
                        2'd2:    res[11:8] <= sl_f;
                        default: res       <= res;
                    endcase
                    // Last nibble goes straight to the outputs alongside the stored ones
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        f      <= full;
                        c_out  <= sl_c;
                        a_eq_b <= (full == 16'hFFFF);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq16.sv
// Directed-vector bench for ula_seq16 with hand-computed expected results.
module tb_ula_seq16;
    import ula_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        c_in;
    logic [15:0] f;
    logic        c_out;
    logic        a_eq_b;
    logic        busy;
    logic        done;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] last_f  = 16'h0000;

    ula_seq16 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (f),
        .c_out  (c_out),
        .a_eq_b (a_eq_b),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic [3:0] ts, input logic tm, input logic tc,
                          input logic [15:0] ef, input logic chk_c, input logic ec,
                          input logic eeq, input logic disturb);
        int lat;
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; c_in = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                chk({tag, " f_hold"}, 32'(f), 32'(last_f));
                if (disturb) begin
                    start = 1'b1;
                    a = ~a; b = 16'h1357; s = S_ADD; m = 1'b0; c_in = ~c_in;
                end
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " f"}, 32'(f), 32'(ef));
        if (chk_c) chk({tag, " c_out"}, 32'(c_out), 32'(ec));
        chk({tag, " a_eq_b"}, 32'(a_eq_b), 32'(eeq));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        if (disturb) begin
            @(negedge clk);
            chk({tag, " no_queue"}, 32'(busy), 32'd0);
            chk({tag, " f_kept"}, 32'(f), 32'(ef));
        end
        last_f = ef;
    endtask

    initial begin
        int saw_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst f", 32'(f), 32'h0);
        chk("rst c_out", 32'(c_out), 32'd1);
        chk("rst a_eq_b", 32'(a_eq_b), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        rst = 1'b0;

        //     tag     a         b         s       m     c_in  f         chk_c c_out eq    disturb
        run_op("add",  16'h1234, 16'h4321, S_ADD,  1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sub",  16'h5000, 16'h0001, S_SUB,  1'b0, 1'b0, 16'h4FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("eq",   16'h1234, 16'h1234, S_SUB,  1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("wrap", 16'hFFFF, 16'h0000, S_AINC, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("ovf",  16'hFFFF, 16'h0001, S_ADD,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("xor",  16'hF0F0, 16'hFF00, S_XOR,  1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort a run partway through with reset
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; s = S_ADD; m = 1'b0; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort f", 32'(f), 32'h0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort c_out", 32'(c_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("abort no_done", 32'(saw_done), 32'd0);
        last_f = 16'h0000;
        run_op("post", 16'h1234, 16'h4321, S_ADD, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ula_seq16.md
ULA_SEQ16 -- requirements
Module: ula_seq16

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock), then rst input 1 (asynchronous reset, active-high).
REQ-002 The module SHALL have the port start input 1, a one-cycle operation request.
REQ-003 The module SHALL have the ports a input 16 and b input 16, the operands.
REQ-004 The module SHALL have the port s input 4, the 74181 function select.
REQ-005 The module SHALL have the port m input 1, the mode select (1 = logic, 0 = arithmetic).
REQ-006 The module SHALL have the port c_in input 1, an active-low carry-in (0 = carry present).
REQ-007 The module SHALL have the port f output 16, the registered result.
REQ-008 The module SHALL have the port c_out output 1, an active-low registered carry-out of nibble 3.
REQ-009 The module SHALL have the port a_eq_b output 1, registered and high when f == 16'hFFFF.
REQ-010 The module SHALL have the port busy output 1, high while an operation is in progress.
REQ-011 The module SHALL have the port done output 1, a one-cycle completion pulse.

Function
REQ-012 The module SHALL have the FSM states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at edge E0, the module SHALL latch a, b, s, m and c_in, clear the nibble index to 0, and enter RUN.
REQ-014 In RUN, the module SHALL apply latched nibble[idx] of a and b, plus the running carry, to one ula_74181 slice. At each edge it SHALL store the slice f into an internal nibble idx, take the slice c_out as the next carry, and increment idx.
REQ-015 Nibble 0 SHALL use the latched c_in as its carry. Nibbles 1..3 SHALL use the previous nibble's c_out, with active-low polarity preserved and no inversion.
REQ-016 At edge E4 (idx wraps 3->0), the module SHALL load f, c_out and a_eq_b from the internal result, set done=1, and enter DONE.
REQ-017 In DONE, at the next edge the module SHALL clear done and enter IDLE. Latency SHALL be fixed at 4 cycles from the start edge to done high.
REQ-018 busy SHALL be 1 exactly in RUN.
REQ-019 start SHALL be ignored in RUN and DONE, and SHALL NOT be queued.
REQ-020 Input changes during RUN SHALL NOT affect the result.
REQ-021 f, c_out and a_eq_b SHALL change only at E4 and SHALL hold between operations.
REQ-022 With m=1, carry SHALL NOT affect f, and c_out SHALL be the slice value (don't-care for checking).
REQ-023 Arithmetic SHALL be modulo 2^16, with overflow visible only through c_out.

Reset
REQ-024 rst=1 SHALL asynchronously force: state IDLE, idx 0, f 16'h0000, c_out 1 (no carry), a_eq_b 0, busy 0, done 0.
REQ-025 A reset during RUN SHALL abort the operation with no done pulse. The first start after reset release SHALL behave per REQ-013.

Structure
REQ-026 A shared package ula_pkg SHALL hold the state enum, NIBBLES=4, and named s-code constants for the verification bench (S_ADD=4'b1001, S_SUB=4'b0110, S_XOR=4'b0110 with m=1, S_AINC=4'b0000).
REQ-027 The module SHALL instantiate exactly one sub-module, ula_74181 (4-bit combinational slice), reused across all four cycles.

Verification
REQ-028 Add: a=16'h1234, b=16'h4321, s=1001, m=0, c_in=1, start pulse -> done 4 cycles later, f=16'h5555, c_out=1, a_eq_b=0.
REQ-029 Subtract with carry ripple: a=16'h5000, b=16'h0001, s=0110, m=0, c_in=0 -> f=16'h4FFF, c_out=0.
REQ-030 Equality: a=b=16'h1234, s=0110, m=0, c_in=1 -> f=16'hFFFF, a_eq_b=1.
REQ-031 Wrap-around: a=16'hFFFF, s=0000, m=0, c_in=0 -> f=16'h0000, c_out=0.
REQ-032 Logic XOR: a=16'hF0F0, b=16'hFF00, s=0110, m=1 -> f=16'h0FF0. A second start plus operand changes during RUN -> both ignored, result unchanged.
REQ-033 Reset: rst asserted at cycle 2 of RUN -> busy=0, f=0, no done. A fresh start afterwards -> correct result.
